mem_arbiter: RTL

//  Two-master arbiter sharing the single RAM port (synchronous BRAM, fixed read latency) between the CPU (m0) and
//  a second bus master (m1: UART loader / DMA). Round-robin with optional bus lock and a starvation limit.

---
 rtl/mem_arbiter_pkg.sv | 10 +
 rtl/mem_arbiter_if.sv | 24 ++
 rtl/mem_arb_rsp_pipe.sv | 26 ++
 rtl/mem_arbiter.sv | 71 +++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared ids, limits and response-pipe entry type for the RAM arbiter.
package mem_arbiter_pkg;
    typedef enum logic {M0 = 1'b0, M1 = 1'b1} mid_e;
    localparam int RD_LAT_MAX = 4;
    localparam int HOLD_W = 8;
    typedef struct packed {
        logic valid;
        mid_e id;
    } rsp_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one master's request/response port; mem_ram_if: the single BRAM port.
interface mem_arbiter_if;
    logic        req;
    logic        lock;
    logic [31:0] addr;
    logic        ren;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    modport master (output req, lock, addr, ren, wmask, wdata, input gnt, rvalid, rdata);
    modport slave (input req, lock, addr, ren, wmask, wdata, output gnt, rvalid, rdata);
endinterface

interface mem_ram_if;
    logic [31:0] addr;
    logic        ren;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output addr, ren, wmask, wdata, input rdata);
    modport slave (input addr, ren, wmask, wdata, output rdata);
endinterface

// File: rtl/mem_arb_rsp_pipe.sv
// mem_arb_rsp_pipe: RD_LAT-deep {valid,id} shift register steering read responses to their master.
module mem_arb_rsp_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_valid_i,
    input  mid_e       push_id_i,
    output logic [1:0] rvalid_o
);
    rsp_t [RD_LAT-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= {push_valid_i, push_id_i};
            for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rvalid_o[0] = pipe_q[RD_LAT-1].valid && pipe_q[RD_LAT-1].id == M0;
    assign rvalid_o[1] = pipe_q[RD_LAT-1].valid && pipe_q[RD_LAT-1].id == M1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter for one BRAM port, with bus lock and starvation limit.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int MAX_HOLD  = 8,
    parameter bit FIXED_PRI = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave m0,
    mem_arbiter_if.slave m1,
    mem_ram_if.master    s
);
    mid_e              last_q, last_d, win, other;
    logic              lock_q, lock_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              gnt, own_req, oth_req, owned;
    logic [1:0]        rvalid;

    assign other = (last_q == M0) ? M1 : M0;

    // last_q doubles as the lock owner: the owner is always the most recent winner
    always_comb begin
        gnt     = m0.req | m1.req;
        own_req = (last_q == M1) ? m1.req : m0.req;
        oth_req = (last_q == M1) ? m0.req : m1.req;
        owned   = lock_q && own_req;
        win     = (owned && (!oth_req || hold_q < HOLD_W'(MAX_HOLD))) ? last_q
                : owned ? other
                : (m0.req ^ m1.req) ? (m1.req ? M1 : M0)
                : FIXED_PRI ? M0 : other;
        last_d  = gnt ? win : last_q;
        lock_d  = gnt ? ((win == M1) ? m1.lock : m0.lock) : lock_q;
        hold_d  = !gnt ? hold_q
                : (win == last_q && lock_q) ? ((&hold_q) ? hold_q : hold_q + 1'b1)
                : HOLD_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= M1;
            lock_q <= 1'b0;
            hold_q <= '0;
        end else begin
            last_q <= last_d;
            lock_q <= lock_d;
            hold_q <= hold_d;
        end
    end

    assign m0.gnt  = gnt && win == M0;
    assign m1.gnt  = gnt && win == M1;
    assign s.addr  = !gnt ? '0 : (win == M1) ? m1.addr : m0.addr;
    assign s.ren   = gnt && ((win == M1) ? m1.ren : m0.ren);
    assign s.wmask = !gnt ? '0 : (win == M1) ? m1.wmask : m0.wmask;
    assign s.wdata = !gnt ? '0 : (win == M1) ? m1.wdata : m0.wdata;

    mem_arb_rsp_pipe #(.RD_LAT(RD_LAT)) u_rsp_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (s.ren),
        .push_id_i    (win),
        .rvalid_o     (rvalid)
    );

    assign m0.rvalid = rvalid[0];
    assign m1.rvalid = rvalid[1];
    assign m0.rdata  = s.rdata;
    assign m1.rdata  = s.rdata;
endmodule
